// File: rtl/vscale_irq_timer_csr.sv
// Machine-mode interrupt and timer CSR unit: external interrupt capture (edge/level),
// 64-bit mtime/mtimecmp with sticky mtip, and a fixed-priority cause encoder.
module vscale_irq_timer_csr #(
  parameter int                N_EXT        = 8,
  parameter int                TIMER_WIDTH  = 64,
  parameter logic [N_EXT-1:0]  EDGE_DEFAULT = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_EXT-1:0]  ext_interrupts,
  input  logic [11:0]       csr_addr,
  input  logic [2:0]        csr_cmd,
  input  logic [31:0]       csr_wdata,
  output logic [31:0]       csr_rdata,
  output logic              csr_defined,
  input  logic [1:0]        prv,
  input  logic              ie,
  input  logic              interrupt_taken,
  output logic              interrupt_pending,
  output logic              interrupt_request,
  output logic [3:0]        interrupt_code
);

  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTIMECMP  = 12'h321;
  localparam logic [11:0] ADDR_MTIMECMPH = 12'h361;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MTIME     = 12'h701;
  localparam logic [11:0] ADDR_MTIMEH    = 12'h741;
  localparam logic [11:0] ADDR_MEXTMODE  = 12'h7C0;

  localparam logic [1:0] PRV_M = 2'b11;

  localparam logic [31:0] MIE_MASK = (32'((64'd1 << N_EXT) - 64'd1) << 8) | 32'h0000_0088;

  logic [N_EXT-1:0]       s1_q, s1_d;
  logic [N_EXT-1:0]       s2_q, s2_d;
  logic [N_EXT-1:0]       pend_q, pend_d;
  logic [N_EXT-1:0]       mode_q, mode_d;
  logic [31:0]            mie_q, mie_d;
  logic                   msip_q, msip_d;
  logic                   mtip_q, mtip_d;
  logic [TIMER_WIDTH-1:0] mtime_q, mtime_d;
  logic [TIMER_WIDTH-1:0] mtimecmp_q, mtimecmp_d;

  logic [31:0] mip_rd;
  logic [31:0] pending_en;
  logic [31:0] wr_val;
  logic        wr_en;
  logic        wr_mie, wr_mip, wr_cmp, wr_cmph, wr_time, wr_timeh, wr_mode;
  logic        unused_cmd_access;

  assign unused_cmd_access = csr_cmd[2];

  // Level sources show the first synchronizer stage directly; edge sources show the latch.
  always_comb begin
    mip_rd    = '0;
    mip_rd[3] = msip_q;
    mip_rd[7] = mtip_q;
    for (int i = 0; i < N_EXT; i++) begin
      mip_rd[8+i] = mode_q[i] ? pend_q[i] : s1_q[i];
    end
  end

  always_comb begin
    csr_defined = 1'b1;
    csr_rdata   = '0;
    case (csr_addr)
      ADDR_MIE:       csr_rdata = mie_q;
      ADDR_MIP:       csr_rdata = mip_rd;
      ADDR_MTIMECMP:  csr_rdata = mtimecmp_q[31:0];
      ADDR_MTIMECMPH: csr_rdata = mtimecmp_q[TIMER_WIDTH-1:32];
      ADDR_MTIME:     csr_rdata = mtime_q[31:0];
      ADDR_MTIMEH:    csr_rdata = mtime_q[TIMER_WIDTH-1:32];
      ADDR_MEXTMODE:  csr_rdata = 32'(mode_q);
      default:        csr_defined = 1'b0;
    endcase
  end

  always_comb begin
    case (csr_cmd[1:0])
      2'b01:   wr_val = csr_wdata;
      2'b10:   wr_val = csr_rdata | csr_wdata;
      2'b11:   wr_val = csr_rdata & ~csr_wdata;
      default: wr_val = csr_rdata;
    endcase
  end

  assign wr_en    = csr_defined & (csr_cmd[1] | csr_cmd[0]);
  assign wr_mie   = wr_en & (csr_addr == ADDR_MIE);
  assign wr_mip   = wr_en & (csr_addr == ADDR_MIP);
  assign wr_cmp   = wr_en & (csr_addr == ADDR_MTIMECMP);
  assign wr_cmph  = wr_en & (csr_addr == ADDR_MTIMECMPH);
  assign wr_time  = wr_en & (csr_addr == ADDR_MTIME);
  assign wr_timeh = wr_en & (csr_addr == ADDR_MTIMEH);
  assign wr_mode  = wr_en & (csr_addr == ADDR_MEXTMODE);

  assign pending_en        = mip_rd & mie_q;
  assign interrupt_pending = |pending_en;
  assign interrupt_request = (prv == PRV_M) ? (ie & interrupt_pending) : interrupt_pending;

  // Lowest external index wins, so it is applied last.
  always_comb begin
    interrupt_code = 4'd0;
    if (pending_en[7]) interrupt_code = 4'd1;
    for (int i = N_EXT - 1; i >= 0; i--) begin
      if (pending_en[8+i]) interrupt_code = 4'(i + 2);
    end
  end

  always_comb begin
    s1_d = ext_interrupts;
    s2_d = s1_q;
    for (int i = 0; i < N_EXT; i++) begin
      if (!mode_q[i]) begin
        pend_d[i] = 1'b0;
      end else if (s1_q[i] & ~s2_q[i]) begin
        pend_d[i] = 1'b1;
      end else if ((wr_mip & ~wr_val[8+i]) ||
                   (interrupt_taken && (interrupt_code == 4'(i + 2)))) begin
        pend_d[i] = 1'b0;
      end else begin
        pend_d[i] = pend_q[i];
      end
    end
  end

  always_comb begin
    mie_d  = wr_mie  ? (wr_val & MIE_MASK) : mie_q;
    msip_d = wr_mip  ? wr_val[3]           : msip_q;
    mode_d = wr_mode ? wr_val[N_EXT-1:0]   : mode_q;
  end

  // A write to either mtime half replaces that cycle's increment.
  always_comb begin
    mtime_d = mtime_q + TIMER_WIDTH'(1);
    if (wr_time)  mtime_d = {mtime_q[TIMER_WIDTH-1:32], wr_val};
    if (wr_timeh) mtime_d = {wr_val, mtime_q[31:0]};

    mtimecmp_d = mtimecmp_q;
    if (wr_cmp)  mtimecmp_d[31:0]             = wr_val;
    if (wr_cmph) mtimecmp_d[TIMER_WIDTH-1:32] = wr_val;

    if (wr_cmp | wr_cmph) mtip_d = 1'b0;
    else                  mtip_d = mtip_q | (mtime_q >= mtimecmp_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q       <= '0;
      s2_q       <= '0;
      pend_q     <= '0;
      mode_q     <= EDGE_DEFAULT;
      mie_q      <= '0;
      msip_q     <= 1'b0;
      mtip_q     <= 1'b0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      pend_q     <= pend_d;
      mode_q     <= mode_d;
      mie_q      <= mie_d;
      msip_q     <= msip_d;
      mtip_q     <= mtip_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
    end
  end

endmodule

// File: tb/tb_vscale_irq_timer_csr.sv
// Bench for vscale_irq_timer_csr: a per-cycle behavioural model checked on every
// falling edge, plus directed scenarios with hand-computed literal expectations.
module tb_vscale_irq_timer_csr;

  localparam int N = 8;
  localparam logic [11:0] A_MIE  = 12'h304, A_CMP  = 12'h321, A_CMPH = 12'h361;
  localparam logic [11:0] A_MIP  = 12'h344, A_TIME = 12'h701, A_TIMH = 12'h741;
  localparam logic [11:0] A_MEXT = 12'h7C0;
  localparam logic [2:0]  C_IDLE = 3'd0, C_READ = 3'd4, C_WRITE = 3'd5, C_SET = 3'd6, C_CLR = 3'd7;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  ext;
  logic [11:0]   addr;
  logic [2:0]    cmd;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          defined;
  logic [1:0]    prv;
  logic          ie;
  logic          taken;
  logic          pending;
  logic          request;
  logic [3:0]    code;

  vscale_irq_timer_csr #(.N_EXT(N), .TIMER_WIDTH(64), .EDGE_DEFAULT('0)) dut (
    .clk(clk), .reset(reset), .ext_interrupts(ext),
    .csr_addr(addr), .csr_cmd(cmd), .csr_wdata(wdata),
    .csr_rdata(rdata), .csr_defined(defined),
    .prv(prv), .ie(ie), .interrupt_taken(taken),
    .interrupt_pending(pending), .interrupt_request(request), .interrupt_code(code)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  // Model state
  logic [N-1:0]    m_s1, m_s2, m_latch, m_edge;
  logic [31:0]     m_mie;
  logic            m_msip, m_mtip;
  longint unsigned m_time, m_cmp;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_mip();
    logic [31:0] r;
    r = '0;
    r[3] = m_msip;
    r[7] = m_mtip;
    for (int i = 0; i < N; i++) r[8+i] = m_edge[i] ? m_latch[i] : m_s1[i];
    return r;
  endfunction

  function automatic logic m_owned(input logic [11:0] a);
    return a inside {A_MIE, A_CMP, A_CMPH, A_MIP, A_TIME, A_TIMH, A_MEXT};
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      A_MIE:   return m_mie;
      A_MIP:   return m_mip();
      A_CMP:   return 32'(m_cmp);
      A_CMPH:  return 32'(m_cmp >> 32);
      A_TIME:  return 32'(m_time);
      A_TIMH:  return 32'(m_time >> 32);
      A_MEXT:  return 32'(m_edge);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] m_code();
    logic [31:0] en;
    en = m_mip() & m_mie;
    for (int i = 0; i < N; i++) if (en[8+i]) return 4'(2 + i);
    if (en[7]) return 4'd1;
    return 4'd0;
  endfunction

  function automatic logic m_request();
    logic p;
    p = |(m_mip() & m_mie);
    return (prv == 2'b11) ? (ie & p) : p;
  endfunction

  task automatic m_step();
    logic [31:0]     cur, val;
    logic            wr, ntip;
    logic [3:0]      c;
    logic [N-1:0]    nlatch;
    longint unsigned ntime;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_latch = '0; m_edge = '0;
      m_mie = '0; m_msip = 1'b0; m_mtip = 1'b0;
      m_time = 0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
      return;
    end
    cur = m_read(addr);
    c   = m_code();
    case (cmd[1:0])
      2'd1:    val = wdata;
      2'd2:    val = cur | wdata;
      2'd3:    val = cur & ~wdata;
      default: val = cur;
    endcase
    wr = (cmd[1:0] != 2'd0) && m_owned(addr);

    ntime = m_time + 1;
    if (wr && addr == A_TIME) ntime = (m_time & 64'hFFFF_FFFF_0000_0000) | 64'(val);
    if (wr && addr == A_TIMH) ntime = (64'(val) << 32) | (m_time & 64'h0000_0000_FFFF_FFFF);

    ntip = (wr && (addr == A_CMP || addr == A_CMPH)) ? 1'b0 : (m_mtip || (m_time >= m_cmp));

    for (int i = 0; i < N; i++) begin
      if (!m_edge[i])                 nlatch[i] = 1'b0;
      else if (m_s1[i] && !m_s2[i])   nlatch[i] = 1'b1;
      else if ((wr && addr == A_MIP && !val[8+i]) || (taken && c == 4'(2 + i)))
                                      nlatch[i] = 1'b0;
      else                            nlatch[i] = m_latch[i];
    end

    if (wr && addr == A_CMP)  m_cmp = (m_cmp & 64'hFFFF_FFFF_0000_0000) | 64'(val);
    if (wr && addr == A_CMPH) m_cmp = (64'(val) << 32) | (m_cmp & 64'h0000_0000_FFFF_FFFF);
    if (wr && addr == A_MIE)  m_mie = val & 32'h0000_FF88;
    if (wr && addr == A_MIP)  m_msip = val[3];
    if (wr && addr == A_MEXT) m_edge = val[N-1:0];
    m_s2    = m_s1;
    m_s1    = ext;
    m_time  = ntime;
    m_mtip  = ntip;
    m_latch = nlatch;
  endtask

  // Inputs change 2 time units after the rising edge, so the falling edge sees
  // exactly what the next rising edge will sample.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_defined", 32'(defined), 32'(m_owned(addr)));
      check("cyc_rdata",   rdata,        m_read(addr));
      check("cyc_pending", 32'(pending), 32'(|(m_mip() & m_mie)));
      check("cyc_request", 32'(request), 32'(m_request()));
      check("cyc_code",    32'(code),    32'(m_code()));
    end
    m_step();
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic csr_op(input logic [2:0] c, input logic [11:0] a, input logic [31:0] d);
    cmd = c; addr = a; wdata = d;
    tick();
    cmd = C_IDLE;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    addr = a; cmd = C_READ;
    #1;
    d = rdata;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    reset = 1'b1; ext = '0; addr = '0; cmd = C_IDLE; wdata = '0;
    prv = 2'b11; ie = 1'b0; taken = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;

    // Reset state
    rd(A_MIE, d);   check("rst_mie", d, 32'h0);
    rd(A_MIP, d);   check("rst_mip", d, 32'h0);
    rd(A_CMP, d);   check("rst_cmp", d, 32'hFFFF_FFFF);
    rd(A_CMPH, d);  check("rst_cmph", d, 32'hFFFF_FFFF);
    rd(A_MEXT, d);  check("rst_mext", d, 32'h0);
    check("rst_request", 32'(request), 32'h0);
    check("rst_code", 32'(code), 32'h0);
    tick();
    rd(A_TIME, d);  check("mtime_first_cycle", d, 32'h1);

    // Timer compare
    csr_op(C_WRITE, A_CMPH, 32'h0);
    csr_op(C_WRITE, A_CMP, 32'h20);
    csr_op(C_WRITE, A_MIE, 32'h80);
    rd(A_MIP, d);   check("timer_not_yet", d, 32'h0);
    prv = 2'b11; ie = 1'b1;
    for (int k = 0; k < 64 && !request; k++) tick();
    check("timer_request", 32'(request), 32'h1);
    check("timer_code", 32'(code), 32'h1);
    rd(A_MIP, d);   check("timer_mip", d, 32'h80);
    rd(A_TIME, d);  check("timer_mtime", d, 32'h21);
    csr_op(C_WRITE, A_CMP, 32'h1000);
    rd(A_MIP, d);   check("timer_cmp_clear", d, 32'h0);
    check("timer_req_clear", 32'(request), 32'h0);
    csr_op(C_WRITE, A_CMPH, 32'hFFFF_FFFF);

    // Edge capture on ext[0]
    csr_op(C_WRITE, A_MEXT, 32'h1);
    csr_op(C_WRITE, A_MIE, 32'h100);
    ext = 8'h01; tick(); ext = 8'h00;
    rd(A_MIP, d);   check("edge_not_yet", d, 32'h0);
    tick();
    rd(A_MIP, d);   check("edge_set", d, 32'h100);
    check("edge_code", 32'(code), 32'h2);
    check("edge_request", 32'(request), 32'h1);
    tick(); tick();
    rd(A_MIP, d);   check("edge_held", d, 32'h100);
    taken = 1'b1; tick(); taken = 1'b0;
    rd(A_MIP, d);   check("edge_taken_clr", d, 32'h0);
    ext = 8'h01; tick(); ext = 8'h00; tick();
    rd(A_MIP, d);   check("edge_reset_again", d, 32'h100);
    ext = 8'h01; tick(); ext = 8'h00;
    taken = 1'b1; tick(); taken = 1'b0;
    rd(A_MIP, d);   check("edge_set_wins", d, 32'h100);
    csr_op(C_WRITE, A_MEXT, 32'h0);
    rd(A_MIP, d);   check("edge_to_level_drop", d, 32'h0);

    // Level sources and priority
    csr_op(C_WRITE, A_MIE, 32'h988);
    csr_op(C_WRITE, A_CMPH, 32'h0);
    csr_op(C_WRITE, A_CMP, 32'h0);
    ext = 8'h09; tick();
    rd(A_MIP, d);   check("lvl_mip", d, 32'h980);
    check("lvl_code_ext0", 32'(code), 32'h2);
    ext = 8'h08; tick();
    check("lvl_code_ext3", 32'(code), 32'h5);
    ext = 8'h00; tick();
    check("lvl_code_timer", 32'(code), 32'h1);

    // Software interrupt and privilege gating
    csr_op(C_WRITE, A_CMPH, 32'hFFFF_FFFF);
    prv = 2'b00; ie = 1'b0;
    csr_op(C_SET, A_MIP, 32'h8);
    csr_op(C_WRITE, A_MIE, 32'h8);
    check("sw_request_u", 32'(request), 32'h1);
    check("sw_pending", 32'(pending), 32'h1);
    check("sw_code", 32'(code), 32'h0);
    prv = 2'b11; #1;
    check("sw_request_m_ie0", 32'(request), 32'h0);
    csr_op(C_CLR, A_MIP, 32'h8);
    rd(A_MIP, d);   check("sw_cleared", d, 32'h0);

    // mtime carry and unowned address
    csr_op(C_WRITE, A_TIME, 32'hFFFF_FFFF);
    csr_op(C_WRITE, A_TIMH, 32'h0);
    tick();
    rd(A_TIME, d);  check("carry_lo", d, 32'h0);
    rd(A_TIMH, d);  check("carry_hi", d, 32'h1);
    csr_op(C_WRITE, 12'h305, 32'h1234);
    addr = 12'h305; #1;
    check("unowned_defined", 32'(defined), 32'h0);
    check("unowned_rdata", rdata, 32'h0);
    rd(A_MIE, d);   check("unowned_no_write", d, 32'h8);

    // Reset beats a concurrent write
    reset = 1'b1; cmd = C_WRITE; addr = A_MIE; wdata = 32'h988;
    tick();
    reset = 1'b0; cmd = C_IDLE;
    rd(A_MIE, d);   check("midrst_mie", d, 32'h0);
    rd(A_CMPH, d);  check("midrst_cmph", d, 32'hFFFF_FFFF);
    check("midrst_code", 32'(code), 32'h0);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/vscale_irq_timer_csr.md
# vscale_irq_timer_csr

Parametrised interrupt/timer CSR unit for the vscale core, next generation of the machine-mode interrupt and timer CSRs. Provides N_EXT external interrupt sources with runtime-selectable edge/level capture, a full-width `>=` timer comparator, and a fixed priority encoder producing a real interrupt cause code. Sits beside the CSR file: it decodes its own CSR addresses, returns read data, and drives the interrupt request and cause into the pipeline control.

## Interface
- N_EXT, 8: external interrupt sources; legal range 1..14.
- TIMER_WIDTH, 64: mtime/mtimecmp width; fixed at 64 (two 32-bit halves).
- EDGE_DEFAULT, 0: reset value of mextmode[N_EXT-1:0]; 1 = edge, 0 = level.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- ext_interrupts  in  N_EXT  asynchronous external interrupt lines.
- csr_addr  in  12  CSR address.
- csr_cmd  in  3  CSR command, same encoding as the CSR file (cmd[2] = access, SET/CLEAR/WRITE).
- csr_wdata  in  32  CSR write operand.
- csr_rdata  out  32  read data for csr_addr (combinational); 0 if not owned.
- csr_defined  out  1  csr_addr is owned by this block.
- prv  in  2  current privilege.
- ie  in  1  global interrupt enable (mstatus).
- interrupt_taken  in  1  pipeline entered the trap for the current interrupt_code this cycle.
- interrupt_pending  out  1  |(mip & mie).
- interrupt_request  out  1  interrupt must be taken.
- interrupt_code  out  4  cause code of highest-priority enabled pending source.

## Operation
- CSR map: MIE 0x304, MTIMECMP 0x321, MTIMECMPH 0x361, MIP 0x344, MTIME 0x701, MTIMEH 0x741, MEXTMODE 0x7C0. Any other address: csr_defined=0, no write.
- Write value: WRITE = csr_wdata; SET = rdata|wdata; CLEAR = rdata&~wdata. Writes occur when cmd[1]|cmd[0].
- mip layout: bit3 msip, bit7 mtip, bits [8+:N_EXT] ext pending; all other bits read 0. mie uses the same layout; non-existent bits are hardwired 0.
- Synchronizer: s1 <= ext_interrupts, s2 <= s1. Level source: pending = s1. Edge source: pending set on s1&~s2.
- Edge-pending clear: mip write with that bit 0, or interrupt_taken while that source is the encoded one. A set in the same cycle wins over a clear. Level bits and mtip ignore mip writes; msip is R/W.
- Timer: mtime += 1 every cycle, carry across halves. A write to either half loads that half and suppresses the increment that cycle. mtip is set when mtime >= mtimecmp (unsigned, 64-bit). It is cleared by a write to MTIMECMP or MTIMECMPH; in the same cycle the clear wins.
- Priority: ext[0] highest … ext[N_EXT-1], then timer, then software. Codes: software 0, timer 1, ext i = 2+i. When nothing is pending, interrupt_code = 0.
- interrupt_request: prv==U → interrupt_pending; prv==M → ie & interrupt_pending; other prv → interrupt_pending.

## Timing
- Reset values: mie 0, msip 0, mtip 0, ext pending 0, s1/s2 0, mtime 0, mtimecmp all-ones, mextmode EDGE_DEFAULT. Outputs after reset: interrupt_pending 0, interrupt_request 0, interrupt_code 0.
- csr_rdata, csr_defined, interrupt_* are combinational from registered state and inputs; CSR writes are visible on the next cycle.
- Input rising before edge k: a level bit is visible in mip after edge k. An edge bit is visible after edge k+1.
- mtip is visible the cycle after mtime first satisfies `>=`. mtime wraps from all-ones to 0 without setting flags.
- Changing mextmode takes effect next cycle. Switching edge→level drops any latched edge pending. Switching level→edge starts with pending 0.
- Reset mid-operation clears all state on that edge regardless of concurrent writes.

## Test plan
- Reset, read all CSRs → mie 0, mip 0, mtime ≥ 1 after first cycle, mtimecmp 0xFFFFFFFF/0xFFFFFFFF, interrupt_request 0.
- Write mtimecmp=0x20, MTIMECMPH=0, mie=0x80, prv=M ie=1 → mtip and interrupt_request rise once mtime ≥ 0x20, code 1; write MTIMECMP → mtip 0 next cycle.
- mextmode bit0=1, 1-cycle pulse on ext[0], mie=0x100 → mip bit8 set two cycles later and held. interrupt_taken with code 2 → bit8 cleared. A pulse coincident with the clear leaves bit8 set.
- Level ext[3] high, ext[0] level high, timer pending, all enabled → code 2. Drop ext[0] → code 5. Drop ext[3] → code 1.
- prv=U, ie=0, msip set via CSR SET 0x8, mie=0x8 → interrupt_request 1, code 0. prv=M, ie=0 → interrupt_request 0.
- Write MTIME=0xFFFFFFFF, MTIMEH=0 → next cycles read MTIME=0, MTIMEH=1 (carry). An unowned address such as 0x305 → csr_defined 0, rdata 0.
